updown_step_counter: RTL and testbench

Registered up/down counter with a command handshake. It holds a WIDTH-bit count and accepts load, clear and multi-step up/down commands. It walks the count one increment or decrement per clock and reports completion and wrap-around. It is the sequential stage around the team's incrementer/decrementer datapath: it supplies the operand and direction each cycle and captures the result and carry.

---
 rtl/updown_step_counter.sv | 133 +++++++++++++
 tb/tb_updown_step_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_step_counter.sv
// Up/down step counter with a command handshake: load, clear, and N-step up/down
// walks one increment/decrement per clock, reporting done, sticky wrap and carry pulses.
module updown_step_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             carry
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_UP    = 2'b01,
      OP_DOWN  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] remaining_q;
   logic             dir_up_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             wrap_q;
   logic             carry_q;

   logic [WIDTH:0]   ext_d;
   logic [WIDTH-1:0] step_d;
   logic             step_cy_d;

   // Incrementer/decrementer datapath; the extra MSB is the carry (up) or borrow (down).
   always_comb begin
      ext_d     = dir_up_q ? ({1'b0, count_q} + ONE_EXT) : ({1'b0, count_q} - ONE_EXT);
      step_d    = ext_d[WIDTH-1:0];
      step_cy_d = ext_d[WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         remaining_q <= '0;
         dir_up_q    <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         carry_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  wrap_q  <= 1'b0;
                  ready_q <= 1'b0;
                  unique case (op_e'(cmd_op))
                     OP_LOAD: begin
                        count_q <= cmd_data;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     OP_CLEAR: begin
                        count_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     OP_UP, OP_DOWN: begin
                        dir_up_q <= (op_e'(cmd_op) == OP_UP);
                        if (cmd_data == '0) begin
                           done_q  <= 1'b1;
                           state_q <= S_DONE;
                        end else begin
                           remaining_q <= cmd_data;
                           busy_q      <= 1'b1;
                           state_q     <= S_RUN;
                        end
                     end
                  endcase
               end
            end
            S_RUN: begin
               count_q     <= step_d;
               remaining_q <= remaining_q - ONE;
               carry_q     <= step_cy_d;
               if (step_cy_d) begin
                  wrap_q <= 1'b1;
               end
               if (remaining_q == ONE) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = ready_q;
   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_updown_step_counter.sv
// Scoreboard bench for updown_step_counter: each accepted command pushes its expected
// per-cycle output trace, which is popped and compared on every falling edge.
module tb_updown_step_counter;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic         cmd_ready;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         wrap;
   logic         carry;

   typedef struct packed {
      logic [W-1:0] count;
      logic         busy;
      logic         done;
      logic         wrap;
      logic         carry;
      logic         ready;
   } exp_t;

   exp_t         exp_q[$];
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] m_count = '0;
   logic         m_wrap = 1'b0;

   localparam exp_t IDLE_RST = '{count: '0, busy: 1'b0, done: 1'b0, wrap: 1'b0, carry: 1'b0, ready: 1'b1};

   updown_step_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_data (cmd_data),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap),
      .carry    (carry)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [W-1:0] c, input logic b, input logic d,
                       input logic w, input logic cy, input logic r);
      exp_t e;
      e.count = c;
      e.busy  = b;
      e.done  = d;
      e.wrap  = w;
      e.carry = cy;
      e.ready = r;
      exp_q.push_back(e);
   endtask

   // Expected outputs for the cycles following the accept edge, ending with the idle cycle.
   task automatic build(input logic [1:0] op, input logic [W-1:0] data);
      logic cy;
      m_wrap = 1'b0;
      if (op == 2'b00) m_count = data;
      if (op == 2'b11) m_count = '0;
      if (op == 2'b00 || op == 2'b11 || data == '0) begin
         push(m_count, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         push(m_count, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
         push(m_count, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 1; k <= int'(data); k++) begin
            if (op == 2'b01) begin
               cy      = (m_count == {W{1'b1}});
               m_count = m_count + W'(1);
            end else begin
               cy      = (m_count == '0);
               m_count = m_count - W'(1);
            end
            if (cy) m_wrap = 1'b1;
            push(m_count, k < int'(data), k == int'(data), m_wrap, cy, 1'b0);
         end
         push(m_count, 1'b0, 1'b0, m_wrap, 1'b0, 1'b1);
      end
   endtask

   task automatic check_vec(input string name, input exp_t want);
      exp_t act;
      act = {count, busy, done, wrap, carry, cmd_ready};
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got count=%0d busy=%b done=%b wrap=%b carry=%b ready=%b, want count=%0d busy=%b done=%b wrap=%b carry=%b ready=%b",
                  name, act.count, act.busy, act.done, act.wrap, act.carry, act.ready,
                  want.count, want.busy, want.done, want.wrap, want.carry, want.ready);
      end
   endtask

   // Called at a falling edge with the block idle; returns at the falling edge of the idle cycle.
   task automatic issue(input string name, input logic [1:0] op, input logic [W-1:0] data, input bit hold);
      exp_t e;
      int   cyc;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready-before-accept: got %b want 1", name, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      build(op, data);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
      cmd_op   = 2'($urandom);
      cmd_data = W'($urandom);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         cyc++;
         check_vec($sformatf("%s cycle %0d", name, cyc), e);
         if (hold && exp_q.size() > 0) begin
            cmd_op   = 2'($urandom);
            cmd_data = W'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_vec("reset values", IDLE_RST);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = W'(9);
      @(negedge clk);
      check_vec("command ignored in reset", IDLE_RST);
      cmd_valid = 1'b0;
      rst       = 1'b0;
      m_count   = '0;
      m_wrap    = 1'b0;
      @(negedge clk);
      check_vec("idle after release", IDLE_RST);
   endtask

   task automatic test_load();
      issue("load9", 2'b00, W'(9), 1'b0);
   endtask

   task automatic test_up_wrap();
      issue("load14", 2'b00, W'(14), 1'b0);
      issue("up3", 2'b01, W'(3), 1'b0);
   endtask

   task automatic test_down_wrap();
      issue("load1", 2'b00, W'(1), 1'b0);
      issue("down15", 2'b10, W'(15), 1'b0);
   endtask

   task automatic test_zero_clear();
      issue("load5", 2'b00, W'(5), 1'b0);
      issue("up0", 2'b01, W'(0), 1'b0);
      issue("up1_wrap_setup", 2'b01, W'(11), 1'b0);
      issue("clear", 2'b11, W'(7), 1'b0);
   endtask

   task automatic test_back_to_back();
      issue("b2b up2", 2'b01, W'(2), 1'b1);
      issue("b2b load15", 2'b00, W'(15), 1'b1);
      issue("b2b up2wrap", 2'b01, W'(2), 1'b1);
      issue("b2b down3", 2'b10, W'(3), 1'b1);
      issue("b2b clear", 2'b11, W'(4), 1'b0);
   endtask

   task automatic test_reset_mid_run();
      exp_t mid;
      issue("preload0", 2'b00, W'(0), 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = W'(8);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      mid = '{count: W'(3), busy: 1'b1, done: 1'b0, wrap: 1'b0, carry: 1'b0, ready: 1'b0};
      check_vec("mid-run after 3 steps", mid);
      rst = 1'b1;
      #1;
      check_vec("async reset mid-run", IDLE_RST);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_vec($sformatf("held reset %0d", i), IDLE_RST);
      end
      rst     = 1'b0;
      m_count = '0;
      m_wrap  = 1'b0;
      issue("load3 after reset", 2'b00, W'(3), 1'b0);
      @(negedge clk);
      mid = '{count: W'(3), busy: 1'b0, done: 1'b0, wrap: 1'b0, carry: 1'b0, ready: 1'b1};
      check_vec("idle after load3", mid);
   endtask

   initial begin
      test_reset();
      test_load();
      test_up_wrap();
      test_down_wrap();
      test_zero_clear();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
